// File: rtl/switch_allocator_pkg.sv
// Shared router constants: port count, buffer depth, flit width and port indices.
// Imported by the switch allocator and its per-output arbiter.
package switch_allocator_pkg;

    localparam int ROUTER_NUM_PORT   = 5;
    localparam int ROUTER_FIFO_DEPTH = 4;
    localparam int ROUTER_CREDIT_MAX = ROUTER_FIFO_DEPTH;
    localparam int ROUTER_FLIT_W     = 32;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } port_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Stateless round-robin arbiter: grants the first eligible requester at or above
// rr_ptr, wrapping to index 0.
module sa_rr_arbiter
    import switch_allocator_pkg::*;
#(
    parameter int N     = ROUTER_NUM_PORT,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        // Upper segment first, then the wrapped-around lower segment.
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i] && (i >= int'(rr_ptr))) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && eligible[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Credit-based switch allocator: one round-robin arbiter per output, zero-latency
// grants, registered crossbar controls and sticky credit-overflow detection.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter  int NUM_PORT   = ROUTER_NUM_PORT,
    parameter  int CREDIT_MAX = ROUTER_CREDIT_MAX,
    localparam int CNT_W      = $clog2(CREDIT_MAX + 1),
    localparam int PTR_W      = ptr_width(NUM_PORT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORT-1:0]          sa_request,
    input  logic [NUM_PORT*NUM_PORT-1:0] sa_port,
    input  logic [NUM_PORT-1:0]          credit_in,
    output logic [NUM_PORT-1:0]          sa_grant,
    output logic [NUM_PORT*NUM_PORT-1:0] st_ctrl,
    output logic [NUM_PORT-1:0]          st_valid,
    output logic [NUM_PORT-1:0]          out_credit_avail,
    output logic                         credit_err
);

    logic [CNT_W-1:0]    credit    [NUM_PORT];
    logic [PTR_W-1:0]    rr_ptr    [NUM_PORT];
    logic [PTR_W-1:0]    ptr_next  [NUM_PORT];
    logic [NUM_PORT-1:0] eligible  [NUM_PORT];
    logic [NUM_PORT-1:0] arb_grant [NUM_PORT];
    logic [NUM_PORT-1:0] req_valid;
    logic [NUM_PORT-1:0] out_grant;
    logic [NUM_PORT-1:0] overflow;

    // Malformed (zero or multi-hot) port selects silently drop out here.
    for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_req
        assign req_valid[gi] = rst_n & sa_request[gi]
                             & $onehot(sa_port[gi*NUM_PORT +: NUM_PORT]);
    end

    always_comb begin
        for (int o = 0; o < NUM_PORT; o++) begin
            eligible[o] = '0;
            for (int i = 0; i < NUM_PORT; i++) begin
                eligible[o][i] = req_valid[i] & sa_port[i*NUM_PORT + o]
                               & (credit[o] != '0);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_arb
        sa_rr_arbiter #(
            .N     (NUM_PORT),
            .PTR_W (PTR_W)
        ) u_arb (
            .eligible (eligible[gi]),
            .rr_ptr   (rr_ptr[gi]),
            .grant    (arb_grant[gi])
        );
        assign out_grant[gi]        = |arb_grant[gi];
        assign out_credit_avail[gi] = (credit[gi] != '0);
        assign overflow[gi]         = credit_in[gi] & ~out_grant[gi]
                                    & (credit[gi] == CNT_W'(CREDIT_MAX));
    end

    always_comb begin
        sa_grant = '0;
        for (int o = 0; o < NUM_PORT; o++) begin
            ptr_next[o] = rr_ptr[o];
            for (int i = 0; i < NUM_PORT; i++) begin
                sa_grant[i] = sa_grant[i] | arb_grant[o][i];
                if (arb_grant[o][i]) begin
                    ptr_next[o] = PTR_W'((i + 1) % NUM_PORT);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_PORT; o++) begin
                credit[o] <= CNT_W'(CREDIT_MAX);
                rr_ptr[o] <= '0;
            end
            st_ctrl    <= '0;
            st_valid   <= '0;
            credit_err <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORT; o++) begin
                rr_ptr[o]                         <= ptr_next[o];
                st_ctrl[o*NUM_PORT +: NUM_PORT]   <= arb_grant[o];
                st_valid[o]                       <= out_grant[o];
                if (out_grant[o] && !credit_in[o]) begin
                    credit[o] <= credit[o] - 1'b1;
                end else if (!out_grant[o] && credit_in[o] && !overflow[o]) begin
                    credit[o] <= credit[o] + 1'b1;
                end
            end
            if (|overflow) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter NUM_PORT, default 5, is the number of router ports; every port is both an input and an output (local plus four directions).
REQ-002 Parameter CREDIT_MAX, default 4, is the downstream buffer depth per output port and equals the router FIFO depth.
REQ-003 Derived constant CNT_W = clog2(CREDIT_MAX+1) is the credit counter width.
REQ-004 clk  input  1  system clock; the block has one clock.
REQ-005 rst_n  input  1  system reset, asynchronous assert, active-low.
REQ-006 sa_request  input  NUM_PORT  SA request, one bit per input unit.
REQ-007 sa_port  input  NUM_PORT*NUM_PORT  requested output port per input unit, one-hot; slice i*NUM_PORT+:NUM_PORT belongs to input i.
REQ-008 credit_in  input  NUM_PORT  one-cycle credit return pulse from the downstream router, one bit per output port.
REQ-009 sa_grant  output  NUM_PORT  SA grant, one bit per input unit, combinational.
REQ-010 st_ctrl  output  NUM_PORT*NUM_PORT  registered crossbar select; slice o*NUM_PORT+:NUM_PORT is the one-hot input selected for output o.
REQ-011 st_valid  output  NUM_PORT  registered; 1 means output o carries a flit this cycle.
REQ-012 out_credit_avail  output  NUM_PORT  1 when that output's credit counter is nonzero.
REQ-013 credit_err  output  1  sticky flag for credit overflow.

Function
REQ-014 Input i is eligible for output o only when all of these hold: sa_request[i]=1; its sa_port slice is exactly one-hot with bit o set; credit[o]>0.
REQ-015 A sa_port slice that is zero or has more than one bit set is ignored: that input is never granted and no error is raised.
REQ-016 Each output runs an independent round-robin arbiter over its eligible inputs, searching upward from rr_ptr[o] with wrap-around from NUM_PORT-1 to 0.
REQ-017 At most one input is granted per output per cycle; because each request is one-hot, each input receives at most one grant.
REQ-018 sa_grant is asserted in the same cycle as the request (zero latency); an input unit holds its request until it is granted.
REQ-019 On a grant from input i to output o:
- rr_ptr[o] is set to (i+1) mod NUM_PORT at the next clock edge.
- An output with no grant keeps its rr_ptr unchanged.
REQ-020 st_ctrl and st_valid are driven from registers one cycle after the grant, giving one cycle of switch-traversal latency. In cycles with no grant, st_valid[o]=0 and the st_ctrl slice is 0.
REQ-021 Credit counter credit[o] (CNT_W bits) updates at the clock edge as follows:
- Grant only: decrements by 1.
- credit_in[o] only: increments by 1.
- Both in the same cycle: unchanged.
REQ-022 credit[o] never underflows, because REQ-014 blocks any grant when credit[o]=0.
REQ-023 Overflow rule: if credit_in[o]=1 with no grant while credit[o]=CREDIT_MAX, the counter saturates at CREDIT_MAX and credit_err is set to 1. credit_err stays 1 until reset.
REQ-024 A credit returned in cycle t is usable for arbitration in cycle t+1; there is no combinational bypass from credit_in.

Reset
REQ-025 Asserting rst_n low immediately forces every register, regardless of any in-progress grant:
- credit[o]=CREDIT_MAX
- rr_ptr[o]=0
- st_ctrl=0, st_valid=0
- credit_err=0
REQ-026 While in reset, sa_grant=0 and out_credit_avail is all ones.
REQ-027 Deassertion is synchronized externally; the first arbitration happens on the first clock edge after rst_n rises.

Structure
REQ-028 NUM_PORT, CREDIT_MAX and the port index constants (LOCAL, NORTH, SOUTH, EAST, WEST = 0..4) belong in the shared router package/header, alongside the router width and FIFO-depth macros.
REQ-029 The per-output arbiter is a single sub-module, sa_rr_arbiter, instantiated NUM_PORT times:
- Inputs: eligible vector and rr_ptr.
- Outputs: one-hot grant.
- Holds no state; the pointer registers live in switch_allocator.

Verification
REQ-030 After reset, inputs 1 and 3 both request output 2 every cycle -> grants alternate 1,3,1,3. Each grant is followed one cycle later by st_valid[2]=1 and st_ctrl slice 2 = 5'b00010 or 5'b01000.
REQ-031 Input 0 requests output 4 continuously with no credit_in -> exactly 4 grants. Then out_credit_avail[4]=0 and sa_grant[0]=0. A single credit_in[4] pulse produces exactly one grant, issued the following cycle.
REQ-032 With credit[1]=2, a grant and credit_in[1] in the same cycle -> credit[1] stays 2 and out_credit_avail[1]=1.
REQ-033 credit_in[3] pulsed with credit[3]=4 and no grant -> credit[3]=4 and credit_err=1, which persists through later traffic until rst_n is asserted.
REQ-034 Input 2 with sa_port slice 5'b00110 and sa_request=1 -> sa_grant[2]=0 forever, with no effect on rr_ptr or credits. Simultaneously, inputs 0..4 request five distinct outputs -> all five granted in the same cycle.
REQ-035 rst_n pulsed low in the cycle after a grant -> st_valid drops to 0 asynchronously, all credits return to 4, and rr_ptr is 0 at restart.
